// File: rtl/round_timer_ctrl.sv
// Per-round countdown controller: gates the tick prescaler, times each round,
// takes player answers and keeps the score across a fixed number of rounds.
module round_timer_ctrl #(
  parameter int unsigned ROUND_TIME = 30,
  parameter int unsigned MAX_ROUNDS = 4,
  parameter int unsigned TIME_W     = 6,
  parameter int unsigned ROUND_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause_req,
  input  logic               tick,
  input  logic               answer_valid,
  input  logic               answer_correct,
  output logic               count_en,
  output logic [TIME_W-1:0]  time_left,
  output logic [ROUND_W-1:0] round_idx,
  output logic [ROUND_W:0]   score,
  output logic [2:0]         state,
  output logic               round_done,
  output logic               round_win,
  output logic               timeout,
  output logic               game_over
);

  localparam int unsigned SCORE_W = ROUND_W + 1;
  localparam logic [TIME_W-1:0]  LOAD_VAL   = TIME_W'(ROUND_TIME);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);
  localparam logic [TIME_W-1:0]  TIME_ONE   = TIME_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSED = 3'd3,
    ST_RESULT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e               state_q,      state_d;
  logic                 count_en_q,   count_en_d;
  logic [TIME_W-1:0]    time_left_q,  time_left_d;
  logic [ROUND_W-1:0]   round_idx_q,  round_idx_d;
  logic [SCORE_W-1:0]   score_q,      score_d;
  logic                 round_done_q, round_done_d;
  logic                 round_win_q,  round_win_d;
  logic                 timeout_q,    timeout_d;
  logic                 game_over_q,  game_over_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_en_q   <= 1'b0;
      time_left_q  <= '0;
      round_idx_q  <= '0;
      score_q      <= '0;
      round_done_q <= 1'b0;
      round_win_q  <= 1'b0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_en_q   <= count_en_d;
      time_left_q  <= time_left_d;
      round_idx_q  <= round_idx_d;
      score_q      <= score_d;
      round_done_q <= round_done_d;
      round_win_q  <= round_win_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    time_left_d  = time_left_q;
    round_idx_d  = round_idx_q;
    score_d      = score_q;
    round_win_d  = round_win_q;
    round_done_d = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          score_d     = '0;
          round_idx_d = '0;
        end
      end

      ST_LOAD: begin
        time_left_d = LOAD_VAL;
        state_d     = ST_RUN;
      end

      // An answer beats a tick, and a tick beats a pause request
      ST_RUN: begin
        if (answer_valid) begin
          round_win_d = answer_correct;
          score_d     = score_q + SCORE_W'(answer_correct);
          state_d     = ST_RESULT;
        end else if (tick) begin
          if (time_left_q == TIME_ONE) begin
            time_left_d = '0;
            timeout_d   = 1'b1;
            round_win_d = 1'b0;
            state_d     = ST_RESULT;
          end else if (time_left_q > TIME_ONE) begin
            time_left_d = time_left_q - TIME_ONE;
          end
        end else if (pause_req) begin
          state_d = ST_PAUSED;
        end
      end

      ST_PAUSED: begin
        if (!pause_req) begin
          state_d = ST_RUN;
        end
      end

      ST_RESULT: begin
        round_done_d = 1'b1;
        if (round_idx_q == LAST_ROUND) begin
          state_d = ST_DONE;
        end else begin
          round_idx_d = round_idx_q + ROUND_W'(1);
          state_d     = ST_LOAD;
        end
      end

      ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD;
          score_d     = '0;
          round_idx_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered from next state so these track the state register exactly
    count_en_d  = (state_d == ST_RUN);
    game_over_d = (state_d == ST_DONE);
  end

  assign state      = state_q;
  assign count_en   = count_en_q;
  assign time_left  = time_left_q;
  assign round_idx  = round_idx_q;
  assign score      = score_q;
  assign round_done = round_done_q;
  assign round_win  = round_win_q;
  assign timeout    = timeout_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl: cycle-by-cycle vector table with a scoreboard
// queue, followed by a free-running-tick game that must end on its own.
module tb_round_timer_ctrl;

  localparam int unsigned RT = 3;
  localparam int unsigned MR = 4;
  localparam int unsigned TW = 6;
  localparam int unsigned RW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pause_req = 1'b0;
  logic          tick = 1'b0;
  logic          answer_valid = 1'b0;
  logic          answer_correct = 1'b0;
  logic          count_en;
  logic [TW-1:0] time_left;
  logic [RW-1:0] round_idx;
  logic [RW:0]   score;
  logic [2:0]    state;
  logic          round_done;
  logic          round_win;
  logic          timeout;
  logic          game_over;

  round_timer_ctrl #(
    .ROUND_TIME(RT),
    .MAX_ROUNDS(MR),
    .TIME_W    (TW),
    .ROUND_W   (RW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pause_req     (pause_req),
    .tick          (tick),
    .answer_valid  (answer_valid),
    .answer_correct(answer_correct),
    .count_en      (count_en),
    .time_left     (time_left),
    .round_idx     (round_idx),
    .score         (score),
    .state         (state),
    .round_done    (round_done),
    .round_win     (round_win),
    .timeout       (timeout),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          ce;
    logic [TW-1:0] tl;
    logic [RW-1:0] ri;
    logic [RW:0]   sc;
    logic          rd;
    logic          rw;
    logic          to;
    logic          go;
  } out_t;

  typedef struct packed {
    logic rst;
    logic start;
    logic pause;
    logic tick;
    logic av;
    logic ac;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  out_t act;
  int   checks = 0;
  int   errors = 0;

  assign act = {state, count_en, time_left, round_idx, score,
                round_done, round_win, timeout, game_over};

  function automatic void add(input logic r, s, p, t, a, c,
                              input int st, ce, tl, ri, sc, rd, rw, to, go);
    vec_t v;
    v.rst = r; v.start = s; v.pause = p; v.tick = t; v.av = a; v.ac = c;
    v.exp.st = 3'(st);
    v.exp.ce = 1'(ce);
    v.exp.tl = TW'(tl);
    v.exp.ri = RW'(ri);
    v.exp.sc = (RW+1)'(sc);
    v.exp.rd = 1'(rd);
    v.exp.rw = 1'(rw);
    v.exp.to = 1'(to);
    v.exp.go = 1'(go);
    vecs.push_back(v);
  endfunction

  task automatic check_out(input string name, input out_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got st=%0d ce=%0d tl=%0d ri=%0d sc=%0d rd=%0d rw=%0d to=%0d go=%0d, expected st=%0d ce=%0d tl=%0d ri=%0d sc=%0d rd=%0d rw=%0d to=%0d go=%0d",
               name, act.st, act.ce, act.tl, act.ri, act.sc, act.rd, act.rw, act.to, act.go,
               e.st, e.ce, e.tl, e.ri, e.sc, e.rd, e.rw, e.to, e.go);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int  rd_cnt;
    int  to_cnt;
    int  order_bad;
    bit  prev_to;
    bit  finished;

    // rst, start, pause, tick, av, ac | st, ce, tl, ri, sc, rd, rw, to, go
    add(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,1,1,1,1, 0,0,0,0,0,0,0,0,0);   // IDLE ignores everything but start
    add(0,1,0,0,0,0, 1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 2,1,3,0,0,0,0,0,0);   // count_en two cycles after start
    add(0,0,0,1,0,0, 2,1,2,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 2,1,2,0,0,0,0,0,0);
    add(0,0,0,1,0,0, 2,1,1,0,0,0,0,0,0);
    add(0,0,0,1,0,0, 4,0,0,0,0,0,0,1,0);   // expiring tick -> timeout
    add(0,0,0,0,0,0, 1,0,0,1,0,1,0,0,0);
    add(0,0,0,0,0,0, 2,1,3,1,0,0,0,0,0);
    add(0,0,0,1,0,0, 2,1,2,1,0,0,0,0,0);
    add(0,0,0,0,1,1, 4,0,2,1,1,0,1,0,0);   // correct answer at time_left=2
    add(0,0,0,0,0,0, 1,0,2,2,1,1,1,0,0);
    add(0,0,0,0,0,0, 2,1,3,2,1,0,1,0,0);
    add(0,0,0,1,0,0, 2,1,2,2,1,0,1,0,0);
    for (int k = 0; k < 50; k++) begin
      add(0, (k == 7), 1, (k % 3 == 1), (k % 5 == 2), 1, 3,0,2,2,1,0,1,0,0);
    end
    add(0,0,0,0,0,0, 2,1,2,2,1,0,1,0,0);
    add(0,0,0,1,0,0, 2,1,1,2,1,0,1,0,0);
    add(0,0,0,1,1,1, 4,0,1,2,2,0,1,0,0);   // answer beats expiring tick
    add(0,0,0,0,0,0, 1,0,1,3,2,1,1,0,0);
    add(0,0,0,0,0,0, 2,1,3,3,2,0,1,0,0);
    add(0,0,0,1,0,0, 2,1,2,3,2,0,1,0,0);
    add(0,0,0,1,0,0, 2,1,1,3,2,0,1,0,0);
    add(0,0,1,1,0,0, 4,0,0,3,2,0,0,1,0);   // expiring tick beats pause
    add(0,0,0,0,0,0, 5,0,0,3,2,1,0,0,1);
    add(0,0,0,0,0,0, 5,0,0,3,2,0,0,0,1);
    add(0,0,1,1,1,1, 5,0,0,3,2,0,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,0,0,0,0,0,0);   // restart from DONE
    add(0,0,0,0,0,0, 2,1,3,0,0,0,0,0,0);
    add(0,0,0,0,1,0, 4,0,3,0,0,0,0,0,0);   // wrong answer
    add(0,0,0,0,0,0, 1,0,3,1,0,1,0,0,0);
    add(0,0,0,0,0,0, 2,1,3,1,0,0,0,0,0);
    add(0,1,0,0,0,0, 2,1,3,1,0,0,0,0,0);   // start ignored in RUN
    add(0,0,0,0,1,1, 4,0,3,1,1,0,1,0,0);
    add(0,0,0,0,0,0, 1,0,3,2,1,1,1,0,0);
    add(0,0,0,0,0,0, 2,1,3,2,1,0,1,0,0);
    add(0,0,0,1,0,0, 2,1,2,2,1,0,1,0,0);
    add(1,1,0,1,1,1, 0,0,0,0,0,0,0,0,0);   // reset mid-round wins
    add(0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,1,0,0,0,0, 1,0,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 2,1,3,0,0,0,0,0,0);
    add(0,0,0,1,0,0, 2,1,2,0,0,0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      start          = vecs[i].start;
      pause_req      = vecs[i].pause;
      tick           = vecs[i].tick;
      answer_valid   = vecs[i].av;
      answer_correct = vecs[i].ac;
      exp_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), exp_q.pop_front());
    end

    // Whole game with a tick every cycle and no answers: four timeouts
    @(negedge clk);
    rst = 1'b0; start = 1'b1; pause_req = 1'b0;
    answer_valid = 1'b0; answer_correct = 1'b0; tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_cnt = 0; to_cnt = 0; order_bad = 0; prev_to = 1'b0; finished = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(posedge clk);
      #1;
      if (timeout) to_cnt++;
      if (round_done) begin
        rd_cnt++;
        if (!prev_to) order_bad++;
      end
      prev_to = timeout;
      if (game_over) finished = 1'b1;
    end
    check_val("tick_game_finished", int'(finished), 1);
    check_val("tick_game_round_done", rd_cnt, 4);
    check_val("tick_game_timeouts", to_cnt, 4);
    check_val("tick_game_done_after_timeout", order_bad, 0);
    check_val("tick_game_score", int'(score), 0);
    check_val("tick_game_round_idx", int'(round_idx), 3);
    check_val("tick_game_state", int'(state), 5);
    check_val("tick_game_count_en", int'(count_en), 0);

    tick = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
